// File: rtl/ahb_lite_master_port.sv
// ahb_lite_master_port: valid/ready command port to single-outstanding AHB-Lite NONSEQ SINGLE initiator
module ahb_lite_master_port #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_size,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);
    logic                  ap_valid;
    logic                  ap_write;
    logic [1:0]            ap_size;
    logic [ADDR_WIDTH-1:0] ap_addr;
    logic [DATA_WIDTH-1:0] ap_wdata;
    logic                  dp_valid;
    logic                  dp_write;
    logic [DATA_WIDTH-1:0] dp_wdata;
    logic                  cancel;
    logic                  resp_err;
    logic                  err1;
    logic                  issue;
    logic                  accept;
    logic                  done;
    logic [1:0]            size_n;
    logic [ADDR_WIDTH-1:0] addr_n;

    always_comb begin
        resp_err  = HRESP != 2'b00;
        err1      = dp_valid & ~HREADY & resp_err;
        issue     = ap_valid & ~cancel;
        cmd_ready = ~ap_valid | (HREADY & ~err1 & ~cancel);
        accept    = cmd_valid & cmd_ready;
        done      = dp_valid & HREADY;
        size_n    = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        addr_n    = {cmd_addr[ADDR_WIDTH-1:2],
                     (size_n == 2'd2) ? 1'b0 : cmd_addr[1],
                     (size_n == 2'd0) ? cmd_addr[0] : 1'b0};
    end

    // AP is held through the cancelled cycle so the same command is reissued after an ERROR
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap_valid  <= 1'b0;
            ap_write  <= 1'b0;
            ap_size   <= 2'd0;
            ap_addr   <= '0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            cancel    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                ap_valid <= 1'b1;
                ap_write <= cmd_write;
                ap_size  <= size_n;
                ap_addr  <= addr_n;
                ap_wdata <= cmd_wdata;
            end else if (HREADY & ~cancel) begin
                ap_valid <= 1'b0;
            end
            if (HREADY) begin
                dp_valid <= issue;
                dp_write <= ap_write;
                dp_wdata <= ap_wdata;
            end
            cancel    <= err1 | (cancel & ~HREADY);
            rsp_valid <= done;
            rsp_error <= done & resp_err;
            rsp_rdata <= (done & ~dp_write & ~resp_err) ? HRDATA : '0;
        end
    end

    assign HTRANS    = issue ? 2'b10 : 2'b00;
    assign HADDR     = ap_addr;
    assign HWRITE    = ap_write;
    assign HSIZE     = {1'b0, ap_size};
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = (dp_valid & dp_write) ? dp_wdata : '0;
endmodule

// File: doc/ahb_lite_master_port.md
# ahb_lite_master_port

Single-outstanding-command AHB-Lite initiator that turns a simple valid/ready command interface into pipelined NONSEQ SINGLE transfers on an AHB bus matrix slave port. It drives the address phase and data phase, follows slave wait states, handles the two-cycle ERROR response by cancelling the pipelined address phase and then reissuing it, and returns one response per command. It is the initiator that the matrix's default slave and the peripheral slaves respond to. Typical uses are test/DMA-style masters and bench stimulus in the SoC.

## Interface
- ADDR_WIDTH, 32, HADDR and cmd_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported
- HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, non-bufferable, privileged, data)
- HCLK  in  1  AHB clock; all logic on its rising edge
- HRESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at the HCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  HSIZE[1:0]: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data, lane-aligned by the requester
- rsp_valid  out  1  one-cycle pulse per completed command; no backpressure
- rsp_error  out  1  the completed transfer got an ERROR response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
- HADDR  out  ADDR_WIDTH  address; low bits forced to 0 according to HSIZE (0 for byte, bit 0 for half, bits 1:0 for word)
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HWRITE  out  1  direction
- HSIZE  out  3  {1'b0, size}
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  HPROT_VAL
- HMASTLOCK  out  1  constant 0
- HWDATA  out  DATA_WIDTH  write data during a write data phase, 0 otherwise
- HRDATA  in  DATA_WIDTH  read data
- HREADY  in  1  transfer done / bus ready
- HRESP  in  2  2'b00 OKAY, 2'b01 ERROR; 2'b10 and 2'b11 are treated as ERROR

## Operation
- Two register stages.
  - Address-phase stage AP holds valid, addr, write, size and wdata.
  - Data-phase stage DP holds valid, write and wdata.
- The bus outputs come only from registers:
  - HTRANS = NONSEQ when AP.valid and not cancel, else IDLE.
  - HADDR, HWRITE and HSIZE come from AP.
  - HWDATA comes from DP.wdata when DP.valid and DP.write.
- cmd_ready = ~AP.valid | (HREADY & ~err1 & ~cancel), where err1 = DP.valid & ~HREADY & (HRESP != OKAY).
- When HREADY=1 and there is no error:
  - DP takes AP if HTRANS was NONSEQ; otherwise DP is cleared.
  - AP loads the accepted command, or clears if none was accepted.
- Completion happens when DP.valid & HREADY.
  - Next cycle: rsp_valid=1, rsp_error = (HRESP != OKAY), and rsp_rdata = HRDATA if it was a read with OKAY, else 0.
- Error sequence.
  - Cycle E1 (HREADY=0, ERROR): the cancel register is set at the end of E1.
  - Cycle E2 (HREADY=1, ERROR): HTRANS is IDLE because cancel=1. AP is held, not moved into DP. DP completes with error. cancel is cleared at the end of E2.
  - Cycle E2+1: the held AP command is driven again as NONSEQ.
- An ERROR seen with HREADY=1 but without a preceding E1 (protocol violation by the slave) is still reported as rsp_error=1; no cancel takes place.
- Wait states (HREADY=0, OKAY): AP, DP and all bus outputs are held; cmd_ready=0 while AP.valid.
- Synchronous reset clears AP, DP, cancel and rsp_valid; an in-flight command is dropped with no response.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0
  - HBURST=0, HPROT=HPROT_VAL, HMASTLOCK=0
- Latency with a zero-wait slave:
  - Command accepted at edge T: NONSEQ during T..T+1, data phase T+1..T+2, rsp_valid in cycle T+2..T+3. That is 3 cycles from acceptance to response.
- Throughput: back-to-back commands give continuous NONSEQ, one transfer per cycle.
- Each wait cycle adds one cycle of latency.
- An ERROR adds exactly 2 cycles to a pipelined follower: 1 cancelled IDLE cycle plus its reissue.
- Responses come back in command order, at most one per cycle.

## Test plan
- Single read, zero-wait slave: cmd at addr 0x2000_0004, size 2 -> HTRANS=NONSEQ, HADDR=0x2000_0004 for one cycle; HRDATA=0xDEADBEEF -> rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_error=0, 3 cycles after acceptance.
- Back-to-back write then read with a 2-wait-state slave: the NONSEQ of the read is held 3 cycles; HWDATA=0x12345678 is stable through the waits; two rsp pulses arrive in order.
- Error on a write with a pipelined read to 0x4000_0000 behind it: E1 -> next cycle HTRANS=IDLE; E2 -> rsp_error=1; then NONSEQ to 0x4000_0000 is reissued and completes OKAY.
- Default-slave region: read to an unmapped address -> two-cycle ERROR -> rsp_valid=1, rsp_error=1, rsp_rdata=0, and HRESP returns to OKAY afterwards.
- Alignment: byte write to 0x103 keeps HADDR=0x103; half-word to 0x103 drives HADDR=0x102; word to 0x103 drives HADDR=0x100; HSIZE=0/1/2 respectively.
- Reset asserted during a wait state: the next cycle shows the reset values, and no rsp_valid appears for the dropped command.
